// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between two command sources.
// Latches the granted command, pulses the controller enable, and returns the result on a response channel.
module i2c_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned CNT_W          = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_dev,
    input  logic        req0_rw,
    input  logic [7:0]  req0_reg,
    input  logic [15:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_dev,
    input  logic        req1_rw,
    input  logic [7:0]  req1_reg,
    input  logic [15:0] req1_wdata,
    output logic [6:0]  device_addr,
    output logic        rw,
    output logic [7:0]  reg_addr,
    output logic [15:0] i2c_data,
    output logic        i2c_enable,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [15:0] i2c_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic             ptr;
    logic [CNT_W-1:0] cnt;
    logic             grant1;
    logic             accept;
    logic             timeout;

    // req1 wins when it is the only requester, or when both ask and the pointer favours it
    always_comb begin
        grant1     = req1_valid & (~req0_valid | ptr);
        req0_ready = (state == IDLE) & req0_valid & ~grant1;
        req1_ready = (state == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        i2c_enable = (state == ISSUE) & ~i2c_busy;
        rsp_valid  = (state == RESP);
        timeout    = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (accept)              state_nx = ISSUE;
            ISSUE:     if (!i2c_busy)           state_nx = WAIT_DONE;
            WAIT_DONE: if (i2c_done || timeout) state_nx = RESP;
            RESP:      if (rsp_ready)           state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= 1'b0;
            cnt         <= '0;
            device_addr <= '0;
            rw          <= 1'b0;
            reg_addr    <= '0;
            i2c_data    <= '0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= '0;
        end else begin
            if (accept) begin
                device_addr <= grant1 ? req1_dev   : req0_dev;
                rw          <= grant1 ? req1_rw    : req0_rw;
                reg_addr    <= grant1 ? req1_reg   : req0_reg;
                i2c_data    <= grant1 ? req1_wdata : req0_wdata;
                rsp_id      <= grant1;
            end
            if (state == ISSUE && !i2c_busy) begin
                cnt <= '0;
            end else if (state == WAIT_DONE) begin
                cnt <= cnt + 1'b1;
            end
            // done takes precedence over a coincident timeout
            if (state == WAIT_DONE) begin
                if (i2c_done) begin
                    rsp_data <= (rw && !i2c_nack) ? i2c_rdata : '0;
                    rsp_err  <= i2c_nack ? 2'b01 : 2'b00;
                end else if (timeout) begin
                    rsp_data <= '0;
                    rsp_err  <= 2'b10;
                end
            end
            if (state == RESP && rsp_ready) begin
                ptr <= ~rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a short timeout so the timeout path is reachable.
module tb_i2c_cmd_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_rw;
    logic [6:0]  req0_dev;
    logic [7:0]  req0_reg;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_rw;
    logic [6:0]  req1_dev;
    logic [7:0]  req1_reg;
    logic [15:0] req1_wdata;
    logic [6:0]  device_addr;
    logic        rw;
    logic [7:0]  reg_addr;
    logic [15:0] i2c_data;
    logic        i2c_enable, i2c_busy, i2c_done, i2c_nack;
    logic [15:0] i2c_rdata;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    i2c_cmd_arbiter #(.TIMEOUT_CYCLES(100), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dev(req0_dev),
        .req0_rw(req0_rw), .req0_reg(req0_reg), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dev(req1_dev),
        .req1_rw(req1_rw), .req1_reg(req1_reg), .req1_wdata(req1_wdata),
        .device_addr(device_addr), .rw(rw), .reg_addr(reg_addr), .i2c_data(i2c_data),
        .i2c_enable(i2c_enable), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
        .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic e;
        rst_n = 1'b0;
        req0_valid = 0; req0_dev = '0; req0_rw = 0; req0_reg = '0; req0_wdata = '0;
        req1_valid = 0; req1_dev = '0; req1_rw = 0; req1_reg = '0; req1_wdata = '0;
        i2c_busy = 0; i2c_done = 0; i2c_nack = 0; i2c_rdata = '0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_en",    32'(i2c_enable), 32'h0);
        chk("rst_dev",   32'(device_addr), 32'h0);
        chk("rst_err",   32'(rsp_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // single write from req0
        req0_dev = 7'h48; req0_rw = 0; req0_reg = 8'h01; req0_wdata = 16'hA5C3; req0_valid = 1;
        #1;
        chk("t1_ready0", 32'(req0_ready), 32'h1);
        chk("t1_ready1", 32'(req1_ready), 32'h0);
        chk("t1_en_pre", 32'(i2c_enable), 32'h0);
        tick();
        req0_valid = 0;
        #1;
        chk("t1_ready_once", 32'(req0_ready), 32'h0);
        chk("t1_en",   32'(i2c_enable), 32'h1);
        chk("t1_dev",  32'(device_addr), 32'h48);
        chk("t1_rw",   32'(rw), 32'h0);
        chk("t1_reg",  32'(reg_addr), 32'h01);
        chk("t1_data", 32'(i2c_data), 32'hA5C3);
        tick();
        chk("t1_en_once", 32'(i2c_enable), 32'h0);
        repeat (48) tick();
        chk("t1_wait", 32'(rsp_valid), 32'h0);
        i2c_done = 1; i2c_rdata = 16'hFFFF;
        tick();
        i2c_done = 0;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_id",    32'(rsp_id), 32'h0);
        chk("t1_rsp_data",  32'(rsp_data), 32'h0);
        chk("t1_rsp_err",   32'(rsp_err), 32'h0);
        handshake();
        chk("t1_hold_dev", 32'(device_addr), 32'h48);

        // read from req1 with response backpressure; req0 waits meanwhile
        req1_dev = 7'h50; req1_rw = 1; req1_reg = 8'h10; req1_wdata = 16'h0; req1_valid = 1;
        #1;
        chk("t2_ready1", 32'(req1_ready), 32'h1);
        chk("t2_ready0", 32'(req0_ready), 32'h0);
        tick();
        req1_valid = 0;
        #1;
        chk("t2_en",  32'(i2c_enable), 32'h1);
        chk("t2_dev", 32'(device_addr), 32'h50);
        chk("t2_rw",  32'(rw), 32'h1);
        chk("t2_reg", 32'(reg_addr), 32'h10);
        tick();
        i2c_done = 1; i2c_rdata = 16'h1234;
        tick();
        i2c_done = 0; i2c_rdata = 16'h0;
        req0_dev = 7'h3C; req0_rw = 1; req0_reg = 8'h22; req0_wdata = 16'h0F0F; req0_valid = 1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t2_bp_valid", 32'(rsp_valid), 32'h1);
            chk("t2_bp_id",    32'(rsp_id), 32'h1);
            chk("t2_bp_data",  32'(rsp_data), 32'h1234);
            chk("t2_bp_err",   32'(rsp_err), 32'h0);
            chk("t2_bp_noacc", 32'(req0_ready), 32'h0);
            tick();
        end
        rsp_ready = 1;
        #1;
        chk("t2_hs_noacc", 32'(req0_ready), 32'h0);
        tick();
        rsp_ready = 0;
        #1;
        chk("t2_drop",     32'(rsp_valid), 32'h0);
        chk("t2_next_acc", 32'(req0_ready), 32'h1);

        // that queued req0 read is NACKed
        tick();
        req0_valid = 0;
        #1;
        chk("t3_en",  32'(i2c_enable), 32'h1);
        chk("t3_dev", 32'(device_addr), 32'h3C);
        tick();
        i2c_done = 1; i2c_nack = 1; i2c_rdata = 16'hBEEF;
        tick();
        i2c_done = 0; i2c_nack = 0;
        chk("t3_nack_err",  32'(rsp_err), 32'h1);
        chk("t3_nack_data", 32'(rsp_data), 32'h0);
        handshake();

        // round-robin from reset with both requesters continuously valid
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        req0_dev = 7'h11; req0_rw = 0; req0_reg = 8'hA0; req0_wdata = 16'h0101; req0_valid = 1;
        req1_dev = 7'h22; req1_rw = 1; req1_reg = 8'hB0; req1_wdata = 16'h0202; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            e = ((k % 2) == 1);
            #1;
            chk("rr_ready0", 32'(req0_ready), 32'(!e));
            chk("rr_ready1", 32'(req1_ready), 32'(e));
            tick();
            chk("rr_en",   32'(i2c_enable), 32'h1);
            chk("rr_dev",  32'(device_addr), e ? 32'h22 : 32'h11);
            chk("rr_reg",  32'(reg_addr), e ? 32'hB0 : 32'hA0);
            chk("rr_data", 32'(i2c_data), e ? 32'h0202 : 32'h0101);
            chk("rr_busy_noacc", 32'(req0_ready | req1_ready), 32'h0);
            tick();
            i2c_done = 1; i2c_rdata = 16'h3000 + 16'(k);
            tick();
            i2c_done = 0;
            chk("rr_rsp_id",   32'(rsp_id), 32'(e));
            chk("rr_rsp_data", 32'(rsp_data), e ? (32'h3000 + 32'(k)) : 32'h0);
            handshake();
        end
        req0_valid = 0; req1_valid = 0;

        // timeout: exactly 100 cycles in WAIT_DONE
        req1_dev = 7'h2A; req1_rw = 1; req1_reg = 8'h33; req1_valid = 1;
        tick();
        req1_valid = 0;
        #1;
        chk("to_en", 32'(i2c_enable), 32'h1);
        tick();
        repeat (99) tick();
        chk("to_not_yet", 32'(rsp_valid), 32'h0);
        tick();
        chk("to_valid", 32'(rsp_valid), 32'h1);
        chk("to_err",   32'(rsp_err), 32'h2);
        chk("to_data",  32'(rsp_data), 32'h0);
        chk("to_id",    32'(rsp_id), 32'h1);
        handshake();

        // done coincides with the last timeout cycle
        req0_dev = 7'h2B; req0_rw = 1; req0_reg = 8'h44; req0_valid = 1;
        tick();
        req0_valid = 0;
        tick();
        repeat (99) tick();
        chk("dt_not_yet", 32'(rsp_valid), 32'h0);
        i2c_done = 1; i2c_rdata = 16'h5A5A;
        tick();
        i2c_done = 0;
        chk("dt_valid", 32'(rsp_valid), 32'h1);
        chk("dt_err",   32'(rsp_err), 32'h0);
        chk("dt_data",  32'(rsp_data), 32'h5A5A);
        handshake();

        // controller busy for 20 cycles; a stray done while issuing is ignored
        i2c_busy = 1;
        req0_dev = 7'h4D; req0_rw = 0; req0_reg = 8'h55; req0_wdata = 16'h1111; req0_valid = 1;
        #1;
        chk("bh_ready0", 32'(req0_ready), 32'h1);
        tick();
        req0_valid = 0;
        for (int i = 0; i < 20; i++) begin
            i2c_done = (i == 5);
            #1;
            chk("bh_no_en",  32'(i2c_enable), 32'h0);
            chk("bh_no_rsp", 32'(rsp_valid), 32'h0);
            tick();
        end
        i2c_done = 0; i2c_busy = 0;
        #1;
        chk("bh_en", 32'(i2c_enable), 32'h1);
        tick();
        chk("bh_en_once", 32'(i2c_enable), 32'h0);
        chk("bh_ignored", 32'(rsp_valid), 32'h0);
        i2c_done = 1;
        tick();
        i2c_done = 0;
        chk("bh_valid", 32'(rsp_valid), 32'h1);
        chk("bh_err",   32'(rsp_err), 32'h0);
        handshake();

        // reset while waiting for done
        req1_dev = 7'h60; req1_rw = 1; req1_reg = 8'h77; req1_wdata = 16'h9999; req1_valid = 1;
        tick();
        req1_valid = 0;
        tick();
        repeat (3) tick();
        rst_n = 0;
        i2c_done = 1; i2c_rdata = 16'hCAFE;
        #1;
        chk("mr_dev",   32'(device_addr), 32'h0);
        chk("mr_rw",    32'(rw), 32'h0);
        chk("mr_reg",   32'(reg_addr), 32'h0);
        chk("mr_wdata", 32'(i2c_data), 32'h0);
        chk("mr_en",    32'(i2c_enable), 32'h0);
        chk("mr_valid", 32'(rsp_valid), 32'h0);
        chk("mr_id",    32'(rsp_id), 32'h0);
        chk("mr_data",  32'(rsp_data), 32'h0);
        chk("mr_err",   32'(rsp_err), 32'h0);
        tick();
        i2c_done = 0;
        rst_n = 1;
        tick();
        tick();
        chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
        req0_dev = 7'h0A; req0_rw = 1; req0_reg = 8'h0B; req0_wdata = 16'h0; req0_valid = 1;
        req1_valid = 1;
        #1;
        chk("mr_ptr0", 32'(req0_ready), 32'h1);
        chk("mr_ptr1", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("mr_en_new",  32'(i2c_enable), 32'h1);
        chk("mr_dev_new", 32'(device_addr), 32'h0A);
        tick();
        i2c_done = 1; i2c_rdata = 16'h7777;
        tick();
        i2c_done = 0;
        chk("mr_rsp_id",   32'(rsp_id), 32'h0);
        chk("mr_rsp_data", 32'(rsp_data), 32'h7777);
        chk("mr_rsp_err",  32'(rsp_err), 32'h0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
